// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: issues one IRAM burst per miss,
// writes returned words into the data array, forwards the critical word.
module icache_refill_ctrl #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  localparam int OFS_W     = $clog2(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [PC_SIZE-1:0] miss_pc,
  input  logic               abort,
  output logic               i_miss,
  output logic [PC_SIZE-1:0] iram_address,
  input  logic               word_ready,
  input  logic [WORD_W-1:0]  imem_word,
  output logic               fill_we,
  output logic [OFS_W-1:0]   fill_idx,
  output logic [WORD_W-1:0]  fill_data,
  output logic               fwd_valid,
  output logic [WORD_W-1:0]  fwd_word,
  output logic               fill_done,
  output logic               busy
);

  localparam logic [OFS_W:0] LAST_CNT = (OFS_W + 1)'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [OFS_W:0]     cnt_reg, cnt_next;
  logic [OFS_W-1:0]   crit_reg, crit_next;
  logic [PC_SIZE-1:0] addr_reg, addr_next;
  logic               accept;
  logic               last_word;
  logic               crit_hit;

  logic               i_miss_reg;
  logic               fill_we_reg;
  logic [OFS_W-1:0]   fill_idx_reg;
  logic [WORD_W-1:0]  fill_data_reg;
  logic               fwd_valid_reg;
  logic [WORD_W-1:0]  fwd_word_reg;
  logic               fill_done_reg;
  logic               busy_reg;

  // The DONE exit edge also acts as an IDLE sample, so a held miss_req
  // restarts with i_miss low for exactly the single DONE cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    crit_next  = crit_reg;
    addr_next  = addr_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (miss_req && !abort) begin
          state_next = FILL;
          addr_next  = {miss_pc[PC_SIZE-1:OFS_W], {OFS_W{1'b0}}};
          crit_next  = miss_pc[OFS_W-1:0];
          cnt_next   = '0;
        end
      end
      FILL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (word_ready) begin
          accept   = 1'b1;
          cnt_next = cnt_reg + (OFS_W + 1)'(1);
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_word = accept && (cnt_reg == LAST_CNT);
  assign crit_hit  = accept && (cnt_reg[OFS_W-1:0] == crit_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      crit_reg      <= '0;
      addr_reg      <= '0;
      i_miss_reg    <= 1'b0;
      fill_we_reg   <= 1'b0;
      fill_idx_reg  <= '0;
      fill_data_reg <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_word_reg  <= '0;
      fill_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      crit_reg      <= crit_next;
      addr_reg      <= addr_next;
      i_miss_reg    <= (state_next == FILL);
      busy_reg      <= (state_next != IDLE);
      fill_we_reg   <= accept;
      fwd_valid_reg <= crit_hit;
      fill_done_reg <= last_word;
      if (accept) begin
        fill_idx_reg  <= cnt_reg[OFS_W-1:0];
        fill_data_reg <= imem_word;
      end
      if (crit_hit) begin
        fwd_word_reg <= imem_word;
      end
    end
  end

  assign i_miss       = i_miss_reg;
  assign iram_address = addr_reg;
  assign fill_we      = fill_we_reg;
  assign fill_idx     = fill_idx_reg;
  assign fill_data    = fill_data_reg;
  assign fwd_valid    = fwd_valid_reg;
  assign fwd_word     = fwd_word_reg;
  assign fill_done    = fill_done_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: table of refill scenarios,
// hand-written corner sequences and randomized bursts against a line-level model.
module tb_icache_refill_ctrl;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_pc;
  logic        abort;
  logic        i_miss;
  logic [31:0] iram_address;
  logic        word_ready;
  logic [31:0] imem_word;
  logic        fill_we;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        fwd_valid;
  logic [31:0] fwd_word;
  logic        fill_done;
  logic        busy;

  icache_refill_ctrl #(.PC_SIZE(32), .WORD_W(32), .LINE_WORDS(L)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_pc(miss_pc), .abort(abort),
    .i_miss(i_miss), .iram_address(iram_address), .word_ready(word_ready),
    .imem_word(imem_word), .fill_we(fill_we), .fill_idx(fill_idx),
    .fill_data(fill_data), .fwd_valid(fwd_valid), .fwd_word(fwd_word),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle showing any write-side activity is logged for later comparison.
  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] data;
    logic        fwd;
    logic [31:0] fw;
    logic        done;
    int          c;
  } wr_t;
  wr_t wr_q[$];
  int  exp_cyc[$];

  always @(negedge clk) begin
    if (fill_we || fwd_valid || fill_done)
      wr_q.push_back('{fill_we, fill_idx, fill_data, fwd_valid, fwd_word, fill_done, cyc});
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_miss"}, i_miss, 0);
    check({tag, "_iram_address"}, iram_address, 0);
    check({tag, "_fill_we"}, fill_we, 0);
    check({tag, "_fill_idx"}, fill_idx, 0);
    check({tag, "_fill_data"}, fill_data, 0);
    check({tag, "_fwd_valid"}, fwd_valid, 0);
    check({tag, "_fwd_word"}, fwd_word, 0);
    check({tag, "_fill_done"}, fill_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // mode 0: plain end; 1: keep miss_req high into next_pc; 2: abort+miss during DONE.
  // started: the miss was already accepted by the previous call's DONE exit edge.
  task automatic burst(input logic [31:0] pc, input int gap, input int abort_at,
                       input int mode, input logic [31:0] next_pc, input bit started,
                       input logic [31:0] exp_base, input int exp_crit,
                       input int exp_n, input bit exp_done);
    int  bad0;
    bit  aborted;
    bad0 = bad;
    aborted = 1'b0;
    wr_q.delete();
    exp_cyc.delete();
    if (!started) begin
      @(negedge clk);
      miss_req = 1'b1;
      miss_pc  = pc;
      abort    = 1'b0;
      @(negedge clk);
    end
    miss_req = 1'b0;
    check("i_miss_rise", i_miss, 1);
    check("busy_rise", busy, 1);
    check("iram_address", iram_address, exp_base);
    repeat (3) @(negedge clk);
    for (int k = 0; k < L; k++) begin
      word_ready = 1'b1;
      imem_word  = word_at(exp_base + 32'(k));
      abort      = (k == abort_at);
      if (k != abort_at) exp_cyc.push_back(cyc + 1);
      @(negedge clk);
      word_ready = 1'b0;
      abort      = 1'b0;
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (k != L - 1) repeat (gap) @(negedge clk);
    end
    #1;
    if (aborted) begin
      check("abort_i_miss", i_miss, 0);
      check("abort_busy", busy, 0);
      check("abort_fill_done", fill_done, 0);
    end else begin
      check("done_i_miss", i_miss, 0);
      check("done_busy", busy, 1);
      if (mode == 1) begin
        miss_req = 1'b1;
        miss_pc  = next_pc;
        @(negedge clk);
        check("b2b_i_miss_rise", i_miss, 1);
        check("b2b_iram_address", iram_address, {next_pc[31:3], 3'b000});
      end else if (mode == 2) begin
        abort    = 1'b1;
        miss_req = 1'b1;
        miss_pc  = next_pc;
        @(negedge clk);
        abort    = 1'b0;
        miss_req = 1'b0;
        check("done_abort_no_start", i_miss, 0);
        check("done_abort_busy", busy, 0);
      end else begin
        @(negedge clk);
        check("idle_busy", busy, 0);
      end
      #1;
    end
    check("n_writes", wr_q.size(), exp_n);
    for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
      check("fill_we", wr_q[i].we, 1);
      check("fill_idx", wr_q[i].idx, i);
      check("fill_data", wr_q[i].data, word_at(exp_base + 32'(i)));
      check("fwd_valid", wr_q[i].fwd, (i == exp_crit));
      if (i == exp_crit) check("fwd_word", wr_q[i].fw, word_at(exp_base + 32'(i)));
      check("fill_done", wr_q[i].done, exp_done && (i == L - 1));
      check("write_cycle", wr_q[i].c, exp_cyc[i]);
    end
    $display("txn pc=%h gap=%0d abort_at=%0d mode=%0d writes=%0d/%0d errors=%0d",
             pc, gap, abort_at, mode, wr_q.size(), exp_n, bad - bad0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          gap;
    int          abort_at;
    int          mode;
    logic [31:0] next_pc;
    bit          started;
    logic [31:0] exp_base;
    int          exp_crit;
    int          exp_n;
    bit          exp_done;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int          gap;
    int          ab;
    int          m_n;

    // pc, gap, abort_at (>=8: none), mode, next_pc, started, base, crit, n, done
    vecs[0] = '{32'h13,       1, 8, 1, 32'h40, 1'b0, 32'h10,       3, 8, 1'b1};
    vecs[1] = '{32'h40,       0, 8, 0, 32'h0,  1'b1, 32'h40,       0, 8, 1'b1};
    vecs[2] = '{32'h25,       1, 2, 0, 32'h0,  1'b0, 32'h20,       5, 2, 1'b0};
    vecs[3] = '{32'h0A,       0, 5, 0, 32'h0,  1'b0, 32'h08,       2, 5, 1'b0};
    vecs[4] = '{32'h1F1,      2, 8, 2, 32'h80, 1'b0, 32'h1F0,      1, 8, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 1, 8, 0, 32'h0,  1'b0, 32'hFFFFFFF8, 7, 8, 1'b1};

    rst = 1'b1; miss_req = 1'b0; miss_pc = '0; abort = 1'b0;
    word_ready = 1'b0; imem_word = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      burst(vecs[v].pc, vecs[v].gap, vecs[v].abort_at, vecs[v].mode, vecs[v].next_pc,
            vecs[v].started, vecs[v].exp_base, vecs[v].exp_crit, vecs[v].exp_n,
            vecs[v].exp_done);

    // abort beats miss_req in IDLE
    @(negedge clk);
    miss_req = 1'b1; miss_pc = 32'h77; abort = 1'b1;
    @(negedge clk);
    miss_req = 1'b0; abort = 1'b0;
    check("idle_abort_i_miss", i_miss, 0);
    check("idle_abort_busy", busy, 0);
    @(negedge clk);
    check("idle_abort_i_miss_later", i_miss, 0);
    $display("txn idle abort+miss i_miss=%0d busy=%0d", i_miss, busy);

    // reset in the middle of a dense burst, then a stray word_ready
    wr_q.delete();
    miss_req = 1'b1; miss_pc = 32'h31;
    @(negedge clk);
    miss_req = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      word_ready = 1'b1;
      imem_word  = word_at(32'h30 + 32'(k));
      @(negedge clk);
    end
    word_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    check("midburst_writes", wr_q.size(), 4);
    word_ready = 1'b1; imem_word = 32'hDEAD_BEEF;
    @(negedge clk);
    word_ready = 1'b0;
    #1;
    check("stray_fill_we", fill_we, 0);
    check("stray_writes", wr_q.size(), 4);
    check("stray_i_miss", i_miss, 0);
    $display("txn reset mid-burst writes=%0d fill_we_after=%0d", wr_q.size(), fill_we);

    // randomized bursts against the line-level model
    for (int r = 0; r < 24; r++) begin
      pc  = $urandom;
      gap = $urandom_range(0, 2);
      ab  = $urandom_range(0, 12);
      m_n = (ab < L) ? ab : L;
      burst(pc, gap, ab, 0, 32'h0, 1'b0, pc & ~32'(L - 1), int'(pc % L), m_n, m_n == L);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
